star_serial_frame_rx: RTL and testbench

//  Receives 64-bit words over one star-trigger serial line (rxb[j] after IBUFDS), 8 UART bytes per word.
//  Far-end counterpart of the 64-bit UART word transmitter; delivers each word as a one-cycle strobe.

---
 rtl/star_serial_frame_rx.sv | 150 +++++++++++++++
 tb/tb_star_serial_frame_rx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/star_serial_frame_rx.sv
// star_serial_frame_rx: receives BYTES_PER_WORD UART bytes from one serial line and delivers them as a word strobe.
// Detects stop-bit framing errors and inter-byte timeouts; the first byte received lands in the top byte of O_data.
module star_serial_frame_rx #(
    parameter int CLKS_PER_BIT   = 10,
    parameter int TIMEOUT_CLKS   = 400,
    parameter int BYTES_PER_WORD = 8
) (
    input  logic                        I_clk,
    input  logic                        I_rst,
    input  logic                        I_rxb,
    output logic [8*BYTES_PER_WORD-1:0] O_data,
    output logic                        O_data_vld,
    output logic                        O_frame_err,
    output logic                        O_timeout_err,
    output logic                        O_busy
);
    localparam int DW  = 8 * BYTES_PER_WORD;
    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam int GCW = $clog2(TIMEOUT_CLKS + 1);
    localparam int IXW = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [BCW-1:0] HALF = BCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BCW-1:0] FULL = BCW'(CLKS_PER_BIT - 1);
    localparam logic [GCW-1:0] TMO  = GCW'(TIMEOUT_CLKS - 1);
    localparam logic [IXW-1:0] LAST = IXW'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

    state_t         state_q, state_d;
    logic           rx_m_q, rx_s_q;
    logic [BCW-1:0] baud_q, baud_d;
    logic [GCW-1:0] gap_q, gap_d;
    logic [2:0]     bit_q, bit_d;
    logic [IXW-1:0] idx_q, idx_d;
    logic [7:0]     byte_q, byte_d;
    logic [DW-1:0]  word_q, word_d, data_q, data_d;
    logic           wait_q, wait_d;
    logic           vld_q, vld_d, ferr_q, ferr_d, terr_q, terr_d;
    logic           tick;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            baud_q  <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            data_q  <= '0;
            wait_q  <= 1'b0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            rx_m_q  <= I_rxb;
            rx_s_q  <= rx_m_q;
            state_q <= state_d;
            baud_q  <= baud_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        word_d  = word_q;
        data_d  = data_q;
        wait_d  = wait_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        terr_d  = 1'b0;
        tick    = baud_q == ((state_q == START) ? HALF : FULL);
        unique case (state_q)
            IDLE: begin
                // after a framing error the line must return high before a new start is accepted
                wait_d = wait_q & ~rx_s_q;
                if (!wait_q && !rx_s_q) begin
                    state_d = START;
                    baud_d  = '0;
                    idx_d   = '0;
                end
            end
            START: begin
                baud_d = tick ? '0 : baud_q + 1'b1;
                if (tick) begin
                    state_d = !rx_s_q ? DATA : (idx_q == '0 ? IDLE : GAP);
                    bit_d   = '0;
                end
            end
            DATA: begin
                baud_d = tick ? '0 : baud_q + 1'b1;
                if (tick) begin
                    byte_d  = {rx_s_q, byte_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    state_d = bit_q == 3'd7 ? STOP : DATA;
                end
            end
            STOP: begin
                baud_d = tick ? '0 : baud_q + 1'b1;
                if (tick && rx_s_q) begin
                    word_d  = DW'({word_q, byte_q});
                    gap_d   = '0;
                    idx_d   = idx_q == LAST ? '0 : idx_q + 1'b1;
                    data_d  = idx_q == LAST ? word_d : data_q;
                    vld_d   = idx_q == LAST;
                    state_d = idx_q == LAST ? IDLE : GAP;
                end else if (tick) begin
                    ferr_d  = 1'b1;
                    idx_d   = '0;
                    wait_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (!rx_s_q) begin
                    state_d = START;
                    baud_d  = '0;
                    gap_d   = '0;
                end else if (gap_q == TMO) begin
                    terr_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign O_data        = data_q;
    assign O_data_vld    = vld_q;
    assign O_frame_err   = ferr_q;
    assign O_timeout_err = terr_q;
    assign O_busy        = state_q != IDLE;
endmodule

// File: tb/tb_star_serial_frame_rx.sv
// tb_star_serial_frame_rx: directed and randomized serial-word stimulus checked against a byte-level word model.
`timescale 1ns/1ps
module tb_star_serial_frame_rx;
    localparam int CPB = 10;
    localparam int TMO = 400;
    localparam int BPW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxb = 1'b1;
    logic [63:0] data;
    logic        vld, ferr, terr, busy;

    int tests = 0, fails = 0, cyc = 0;
    int nvld = 0, nferr = 0, nterr = 0, nexcl = 0, vld_cyc = 0, last_start = 0;
    logic [63:0] got_q[$];

    star_serial_frame_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO), .BYTES_PER_WORD(BPW)) dut (
        .I_clk(clk), .I_rst(rst), .I_rxb(rxb), .O_data(data), .O_data_vld(vld),
        .O_frame_err(ferr), .O_timeout_err(terr), .O_busy(busy)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (!rst) begin
        if (vld) begin
            nvld++;
            vld_cyc = cyc;
            got_q.push_back(data);
        end
        if (ferr) nferr++;
        if (terr) nterr++;
        if (int'(vld) + int'(ferr) + int'(terr) > 1) nexcl++;
    end

    initial begin
        #(100 * 80000);
        $display("FAIL watchdog: simulation did not finish within the cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rxb = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        last_start = cyc;
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        drive(stop, CPB);
        drive(1'b1, gap * CPB);
    endtask

    task automatic send_word(input logic [63:0] w, input int gap);
        for (int i = 0; i < BPW; i++) send_byte(w[63-8*i -: 8], 1'b1, gap);
        drive(1'b1, 3 * CPB);
    endtask

    initial begin
        int b_vld, b_ferr, b_terr, base, lat, seen, drop;
        logic [63:0] w, prev, exp_w[6];
        repeat (5) @(negedge clk);
        check("rst_data", data, 64'h0);
        check("rst_vld", 64'(vld), 64'h0);
        check("rst_ferr", 64'(ferr), 64'h0);
        check("rst_terr", 64'(terr), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        rst = 1'b0;
        drive(1'b1, 3 * CPB);

        b_vld = nvld; b_ferr = nferr; b_terr = nterr;
        send_word(64'h0123_4567_89AB_CDEF, 1);
        lat = vld_cyc - last_start;
        check("t1_count", 64'(nvld - b_vld), 64'd1);
        check("t1_data", data, 64'h0123_4567_89AB_CDEF);
        check("t1_latency", 64'(lat >= 9*CPB + CPB/2 && lat <= 9*CPB + CPB/2 + 4), 64'd1);

        send_word(64'hFFFF_FFFF_FFFF_FFFF, 0);
        send_word(64'h0, 0);
        check("t2_count", 64'(nvld - b_vld), 64'd3);
        check("t2_first", got_q[got_q.size()-2], 64'hFFFF_FFFF_FFFF_FFFF);
        check("t2_second", got_q[got_q.size()-1], 64'h0);
        check("t2_errors", 64'(nferr - b_ferr + nterr - b_terr), 64'd0);

        b_vld = nvld;
        for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i), i != 3, 1);
        drive(1'b1, 3 * CPB);
        check("t3_ferr", 64'(nferr - b_ferr), 64'd1);
        check("t3_no_vld", 64'(nvld - b_vld), 64'd0);
        check("t3_data_kept", data, 64'h0);
        w = {$urandom, $urandom};
        send_word(w, 1);
        check("t3_recover_count", 64'(nvld - b_vld), 64'd1);
        check("t3_recover_data", data, w);
        prev = w;

        b_vld = nvld; b_ferr = nferr; b_terr = nterr;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1, 1);
        drive(1'b1, 350);
        check("t4_busy_mid_gap", 64'(busy), 64'd1);
        check("t4_no_early_timeout", 64'(nterr - b_terr), 64'd0);
        drive(1'b1, 150);
        check("t4_timeout", 64'(nterr - b_terr), 64'd1);
        check("t4_busy_drop", 64'(busy), 64'd0);
        check("t4_data_kept", data, prev);
        check("t4_no_other", 64'(nvld - b_vld + nferr - b_ferr), 64'd0);

        b_vld = nvld; b_ferr = nferr; b_terr = nterr;
        drive(1'b0, 2);
        rxb = 1'b1;
        seen = 0; drop = -1;
        for (int i = 1; i <= CPB/2 + 3 + 4; i++) begin
            @(negedge clk);
            if (busy) seen = 1;
            else if (seen == 1 && drop < 0) drop = i;
        end
        check("t5_busy_seen", 64'(seen), 64'd1);
        check("t5_busy_drop_in_time", 64'(drop >= 0 && drop <= CPB/2 + 3), 64'd1);
        check("t5_no_strobes", 64'(nvld - b_vld + nferr - b_ferr + nterr - b_terr), 64'd0);

        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1, 1);
        drive(1'b0, CPB);
        drive(1'b1, 2 * CPB);
        rst = 1'b1;
        drive(1'b1, 3);
        check("t6_rst_data", data, 64'h0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_strobes", 64'({vld, ferr, terr}), 64'd0);
        rst = 1'b0;
        drive(1'b1, 2 * CPB);
        b_vld = nvld; b_ferr = nferr; b_terr = nterr;
        send_word(64'hA5A5_5A5A_0F0F_F0F0, 1);
        check("t6_count", 64'(nvld - b_vld), 64'd1);
        check("t6_data", data, 64'hA5A5_5A5A_0F0F_F0F0);
        check("t6_errors", 64'(nferr - b_ferr + nterr - b_terr), 64'd0);

        b_vld = nvld; b_ferr = nferr;
        drive(1'b0, 40 * CPB);
        drive(1'b1, 3 * CPB);
        check("stuck_ferr_once", 64'(nferr - b_ferr), 64'd1);
        check("stuck_no_vld", 64'(nvld - b_vld), 64'd0);

        base = got_q.size();
        for (int k = 0; k < 6; k++) begin
            w = '0;
            for (int i = 0; i < BPW; i++) w = (w << 8) | 64'($urandom_range(0, 255));
            exp_w[k] = w;
            send_word(w, $urandom_range(0, 3));
        end
        check("rand_count", 64'(got_q.size() - base), 64'd6);
        for (int k = 0; k < 6; k++)
            if (base + k < got_q.size()) check($sformatf("rand_word%0d", k), got_q[base+k], exp_w[k]);
        check("rand_errors", 64'(nferr - b_ferr - 1 + nterr - b_terr), 64'd0);
        check("strobe_exclusive", 64'(nexcl), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
